// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: DEPTH-entry circular buffer
// with up to ISSUE in-order retirements per cycle and a single-cycle flush.
module inst_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int ISSUE = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_pc,
    input  logic [31:0]          in_inst,
    input  logic                 in_exc,
    input  logic                 in_exc_miss,
    input  logic [4:0]           in_exccode,
    output logic [ISSUE-1:0]     out_valid,
    output logic [ISSUE*32-1:0]  out_pc,
    output logic [ISSUE*32-1:0]  out_inst,
    output logic [ISSUE-1:0]     out_exc,
    output logic [ISSUE-1:0]     out_exc_miss,
    output logic [ISSUE*5-1:0]   out_exccode,
    input  logic [1:0]           deq_cnt,
    input  logic                 flush,
    output logic [PTR_W:0]       count,
    output logic [31:0]          perfcnt_full
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] TWO_CNT  = (PTR_W+1)'(2);

    logic [31:0]      pc_mem_q   [DEPTH];
    logic [31:0]      inst_mem_q [DEPTH];
    logic             exc_mem_q  [DEPTH];
    logic             miss_mem_q [DEPTH];
    logic [4:0]       code_mem_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [31:0]      perf_q, perf_d;

    logic [PTR_W-1:0] slot_idx_s [2];
    logic [1:0]       slot_vld_s;
    logic [1:0]       nvalid_s;
    logic [1:0]       eff_s;
    logic             enq_s;
    logic             ready_s;

    assign ready_s      = (count_q != FULL_CNT);
    assign in_ready     = ready_s;
    assign count        = count_q;
    assign perfcnt_full = perf_q;
    assign out_valid    = slot_vld_s[ISSUE-1:0];

    // Slot read indices; the second index wraps on its own at DEPTH-1.
    always_comb begin
        slot_idx_s[0] = rd_ptr_q;
        slot_idx_s[1] = rd_ptr_q + PTR_W'(1);
    end

    // Slot validity: an exception-carrying entry always issues alone in slot 0.
    always_comb begin
        slot_vld_s    = 2'b00;
        slot_vld_s[0] = (count_q != {(PTR_W+1){1'b0}});
        if ((ISSUE == 2) && (count_q >= TWO_CNT)) begin
            slot_vld_s[1] = !exc_mem_q[slot_idx_s[0]] && !exc_mem_q[slot_idx_s[1]];
        end else begin
            slot_vld_s[1] = 1'b0;
        end
    end

    // Slot data, forced to zero on invalid slots.
    always_comb begin
        out_pc       = {(ISSUE*32){1'b0}};
        out_inst     = {(ISSUE*32){1'b0}};
        out_exc      = {ISSUE{1'b0}};
        out_exc_miss = {ISSUE{1'b0}};
        out_exccode  = {(ISSUE*5){1'b0}};
        for (int k = 0; k < ISSUE; k++) begin
            if (slot_vld_s[k]) begin
                out_pc[32*k +: 32]  = pc_mem_q[slot_idx_s[k]];
                out_inst[32*k +: 32] = inst_mem_q[slot_idx_s[k]];
                out_exc[k]          = exc_mem_q[slot_idx_s[k]];
                out_exc_miss[k]     = miss_mem_q[slot_idx_s[k]];
                out_exccode[5*k +: 5] = code_mem_q[slot_idx_s[k]];
            end else begin
                out_pc[32*k +: 32]  = 32'h0000_0000;
                out_inst[32*k +: 32] = 32'h0000_0000;
                out_exc[k]          = 1'b0;
                out_exc_miss[k]     = 1'b0;
                out_exccode[5*k +: 5] = 5'h00;
            end
        end
    end

    // Effective dequeue count, clamped to the number of valid slots.
    always_comb begin
        nvalid_s = {1'b0, slot_vld_s[0]} + {1'b0, slot_vld_s[1]};
        if (deq_cnt < nvalid_s) begin
            eff_s = deq_cnt;
        end else begin
            eff_s = nvalid_s;
        end
    end

    assign enq_s = in_valid && ready_s;

    // Next-state for pointers, occupancy and the full-stall counter; flush wins.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        perf_d   = perf_q;
        if (flush) begin
            rd_ptr_d = {PTR_W{1'b0}};
            wr_ptr_d = {PTR_W{1'b0}};
            count_d  = {(PTR_W+1){1'b0}};
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(eff_s);
            if (enq_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            count_d = count_q + (PTR_W+1)'(enq_s) - (PTR_W+1)'(eff_s);
            if (in_valid && !ready_s) begin
                perf_d = perf_q + 32'd1;
            end else begin
                perf_d = perf_q;
            end
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {(PTR_W+1){1'b0}};
            perf_q   <= 32'h0000_0000;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            perf_q   <= perf_d;
        end
    end

    // Entry storage write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (resetn && enq_s && !flush) begin
            pc_mem_q[wr_ptr_q]   <= in_pc;
            inst_mem_q[wr_ptr_q] <= in_inst;
            exc_mem_q[wr_ptr_q]  <= in_exc;
            miss_mem_q[wr_ptr_q] <= in_exc_miss;
            code_mem_q[wr_ptr_q] <= in_exccode;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: queue-based reference model checked every
// cycle, plus hand-computed expectations at key points of the sequence.
module tb_inst_queue;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;
    localparam int ISSUE = 2;

    logic                clk = 1'b0;
    logic                resetn;
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_pc;
    logic [31:0]         in_inst;
    logic                in_exc;
    logic                in_exc_miss;
    logic [4:0]          in_exccode;
    logic [ISSUE-1:0]    out_valid;
    logic [ISSUE*32-1:0] out_pc;
    logic [ISSUE*32-1:0] out_inst;
    logic [ISSUE-1:0]    out_exc;
    logic [ISSUE-1:0]    out_exc_miss;
    logic [ISSUE*5-1:0]  out_exccode;
    logic [1:0]          deq_cnt;
    logic                flush;
    logic [PTR_W:0]      count;
    logic [31:0]         perfcnt_full;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    inst_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .ISSUE(ISSUE)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_exc(in_exc),
        .in_exc_miss(in_exc_miss), .in_exccode(in_exccode),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
        .out_exc(out_exc), .out_exc_miss(out_exc_miss), .out_exccode(out_exccode),
        .deq_cnt(deq_cnt), .flush(flush), .count(count), .perfcnt_full(perfcnt_full)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic        miss;
        logic [4:0]  code;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_perf;
    bit          model_ok = 1'b0;
    int          m_nv;
    int          m_eff;
    bit          m_rdy;

    logic [1:0]  e_valid;
    logic [63:0] e_pc;
    logic [63:0] e_inst;
    logic [1:0]  e_exc;
    logic [1:0]  e_miss;
    logic [9:0]  e_code;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Number of entries decode may take: two only when neither carries an exception.
    function automatic int model_nvalid();
        if (mq.size() == 0) return 0;
        if (mq.size() >= 2 && !mq[0].exc && !mq[1].exc) return 2;
        return 1;
    endfunction

    // Reference model update on each rising edge.
    always @(posedge clk) begin
        if (!resetn) begin
            mq.delete();
            m_perf   = 32'd0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (flush) begin
                mq.delete();
            end else begin
                m_rdy = (mq.size() < DEPTH);
                m_nv  = model_nvalid();
                m_eff = (int'(deq_cnt) < m_nv) ? int'(deq_cnt) : m_nv;
                if (in_valid && !m_rdy) m_perf = m_perf + 32'd1;
                for (int i = 0; i < m_eff; i++) void'(mq.pop_front());
                if (in_valid && m_rdy)
                    mq.push_back('{in_pc, in_inst, in_exc, in_exc_miss, in_exccode});
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            e_valid = 2'b00; e_pc = 64'd0; e_inst = 64'd0;
            e_exc = 2'b00; e_miss = 2'b00; e_code = 10'd0;
            m_nv = model_nvalid();
            for (int s = 0; s < m_nv; s++) begin
                e_valid[s]        = 1'b1;
                e_pc[32*s +: 32]  = mq[s].pc;
                e_inst[32*s +: 32] = mq[s].inst;
                e_exc[s]          = mq[s].exc;
                e_miss[s]         = mq[s].miss;
                e_code[5*s +: 5]  = mq[s].code;
            end
            chk("count", 64'(count), 64'(mq.size()));
            chk("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
            chk("out_valid", 64'(out_valid), 64'(e_valid));
            chk("out_pc", out_pc, e_pc);
            chk("out_inst", out_inst, e_inst);
            chk("out_exc", 64'(out_exc), 64'(e_exc));
            chk("out_exc_miss", 64'(out_exc_miss), 64'(e_miss));
            chk("out_exccode", 64'(out_exccode), 64'(e_code));
            chk("perfcnt_full", 64'(perfcnt_full), 64'(m_perf));
        end
    end

    task automatic cyc(input logic v, input logic [31:0] pc, input logic e, input logic m,
                       input logic [4:0] c, input logic [1:0] d, input logic f);
        in_valid    = v;
        in_pc       = pc;
        in_inst     = pc ^ 32'hA5A5_0000;
        in_exc      = e;
        in_exc_miss = m;
        in_exccode  = c;
        deq_cnt     = d;
        flush       = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 5'h00, 2'd0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 5'h00, 2'd0, 1'b0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_perf", 64'(perfcnt_full), 64'd0);
        resetn = 1'b1;

        // Fill to full, then stall three cycles.
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 32'h100 + 32'(4*i), 1'b0, 1'b0, 5'h00, 2'd0, 1'b0);
        chk("fill_count", 64'(count), 64'd8);
        chk("fill_ready", 64'(in_ready), 64'd0);
        chk("fill_pc", out_pc, 64'h0000_0104_0000_0100);
        chk("fill_valid", 64'(out_valid), 64'd3);
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 32'h120, 1'b0, 1'b0, 5'h00, 2'd0, 1'b0);
        chk("full_perf", 64'(perfcnt_full), 64'd3);

        // Dual dequeue while refilling across the pointer wrap.
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 5'h00, 2'd2, 1'b0);
        chk("deq2_pc", out_pc, 64'h0000_010C_0000_0108);
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 32'h200 + 32'(4*i), 1'b0, 1'b0, 5'h00, 2'd2, 1'b0);
        chk("wrap_pc", out_pc, 64'h0000_0204_0000_0200);
        chk("wrap_count", 64'(count), 64'd3);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 5'h00, 2'd2, 1'b0);
        chk("one_left", 64'(count), 64'd1);

        // Clamp: one entry, deq_cnt=2.
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 5'h00, 2'd2, 1'b0);
        chk("clamp_count", 64'(count), 64'd0);
        chk("clamp_valid", 64'(out_valid), 64'd0);
        chk("clamp_pc", out_pc, 64'd0);
        chk("clamp_inst", out_inst, 64'd0);

        // Slot 1 reading entry 0 while slot 0 reads entry 7.
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 32'h400 + 32'(4*i), 1'b0, 1'b0, 5'h00, 2'd0, 1'b0);
        cyc(1'b1, 32'h414, 1'b0, 1'b0, 5'h00, 2'd2, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 5'h00, 2'd2, 1'b0);
        chk("pair_pc", out_pc, 64'h0000_0414_0000_0410);
        chk("pair_inst", out_inst, 64'hA5A5_0414_A5A5_0410);
        chk("pair_valid", 64'(out_valid), 64'd3);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 5'h00, 2'd3, 1'b0);
        chk("deq3_count", 64'(count), 64'd0);

        // Exception isolation.
        cyc(1'b1, 32'h300, 1'b0, 1'b0, 5'h00, 2'd0, 1'b0);
        chk("exc_c1_valid", 64'(out_valid), 64'd1);
        cyc(1'b1, 32'h304, 1'b1, 1'b1, 5'h04, 2'd0, 1'b0);
        cyc(1'b1, 32'h308, 1'b0, 1'b0, 5'h00, 2'd0, 1'b0);
        chk("exc_pre_valid", 64'(out_valid), 64'd1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 5'h00, 2'd1, 1'b0);
        chk("exc_pc", out_pc, 64'h0000_0000_0000_0304);
        chk("exc_flag", 64'(out_exc), 64'd1);
        chk("exc_miss", 64'(out_exc_miss), 64'd1);
        chk("exc_code", 64'(out_exccode), 64'h004);
        chk("exc_valid", 64'(out_valid), 64'd1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 5'h00, 2'd2, 1'b0);
        chk("post_exc_pc", out_pc, 64'h0000_0000_0000_0308);
        chk("post_exc_valid", 64'(out_valid), 64'd1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 5'h00, 2'd1, 1'b0);

        // Flush priority over enqueue and dequeue.
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 32'h500 + 32'(4*i), 1'b0, 1'b0, 5'h00, 2'd0, 1'b0);
        chk("pre_flush_count", 64'(count), 64'd5);
        cyc(1'b1, 32'h520, 1'b0, 1'b0, 5'h00, 2'd2, 1'b1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        chk("flush_perf", 64'(perfcnt_full), 64'd3);
        cyc(1'b1, 32'h600, 1'b0, 1'b0, 5'h00, 2'd0, 1'b0);
        chk("after_flush_pc", out_pc, 64'h0000_0000_0000_0600);
        chk("after_flush_count", 64'(count), 64'd1);
        for (int i = 0; i < 7; i++)
            cyc(1'b1, 32'h700 + 32'(4*i), 1'b0, 1'b0, 5'h00, 2'd0, 1'b0);
        cyc(1'b1, 32'h720, 1'b0, 1'b0, 5'h00, 2'd0, 1'b1);
        chk("full_flush_perf", 64'(perfcnt_full), 64'd3);
        chk("full_flush_count", 64'(count), 64'd0);

        // Mid-operation reset.
        for (int i = 0; i < 6; i++)
            cyc(1'b1, 32'h800 + 32'(4*i), 1'b0, 1'b0, 5'h00, 2'd0, 1'b0);
        chk("pre_rst_count", 64'(count), 64'd6);
        resetn = 1'b0;
        cyc(1'b1, 32'h900, 1'b0, 1'b0, 5'h00, 2'd1, 1'b0);
        resetn = 1'b1;
        chk("mrst_count", 64'(count), 64'd0);
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_pc", out_pc, 64'd0);
        chk("mrst_ready", 64'(in_ready), 64'd1);
        chk("mrst_perf", 64'(perfcnt_full), 64'd0);
        cyc(1'b1, 32'hA00, 1'b0, 1'b0, 5'h00, 2'd0, 1'b0);
        chk("post_rst_pc", out_pc, 64'h0000_0000_0000_0A00);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 5'h00, 2'd1, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 5'h00, 2'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
